mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester front end for the shared `memory` model: arbitrates between the instruction cache (read-only line fills) and the data cache (line fills and line evictions). Converts one 128-bit dcache eviction into a burst of 32-bit word stores, issues single-cycle read requests, and routes the delayed fill response back to the requester that owns it. Sits directly upstream of `memory`, between it and both caches.

## Interface
- `ADDRESS_WIDTH`, default 32: word address width, shared with `memory`.
- `FILL_DATA_WIDTH`, default 128: cache line width.
- `STORE_DATA_WIDTH`, default 32: memory store word width.
- `DATA_TRANSFER_TIME`, default 5: memory read latency in cycles. Must equal the `memory` instance value.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ic_req`  in  1  icache read request; held until `ic_ack`.
- `ic_address`  in  ADDRESS_WIDTH  icache line word address.
- `ic_ack`  out  1  one-cycle pulse: request accepted.
- `ic_fill_valid`  out  1  one-cycle pulse: `ic_fill_data` valid.
- `ic_fill_data`  out  FILL_DATA_WIDTH  returned line.
- `dc_req`  in  1  dcache request; held until `dc_ack`.
- `dc_store`  in  1  1 = eviction, 0 = fill; qualified by `dc_req`.
- `dc_address`  in  ADDRESS_WIDTH  dcache line word address.
- `dc_evict_data`  in  FILL_DATA_WIDTH  line to write; word i in bits [32i+31:32i].
- `dc_ack`  out  1  one-cycle acceptance pulse.
- `dc_fill_valid`  out  1  one-cycle pulse: `dc_fill_data` valid.
- `dc_fill_data`  out  FILL_DATA_WIDTH  returned line.
- `mem_req`, `mem_store`  out  1  to `memory.req` / `memory.store`.
- `mem_address`  out  ADDRESS_WIDTH  to `memory.address`.
- `mem_evict_data`  out  STORE_DATA_WIDTH  to `memory.evict_data`.
- `mem_fill_data`  in  FILL_DATA_WIDTH  from `memory.fill_data`.
- `mem_response_valid`  in  1  from `memory.response_valid`.

## Operation
- FF_PER_LINE = FILL_DATA_WIDTH/STORE_DATA_WIDTH (4); BEAT_BITS = log2(FF_PER_LINE).
- States: FLUSH, IDLE, RD_REQ, RD_WAIT, WR.
- FLUSH: entered on reset; flush counter loaded with DATA_TRANSFER_TIME and decremented each cycle; no grants; go to IDLE when counter reaches 0. Drains stale responses already inside the memory pipeline.
- IDLE: sample requests at the edge. When both request, the arbitration policy picks (see Configuration). The granted request's address (low BEAT_BITS forced to 0), owner, and eviction data are captured.
  - A read goes to RD_REQ.
  - A dcache store goes to WR with beat = 0.
- RD_REQ: one cycle. `mem_req`=1, `mem_store`=0, `mem_address`=captured address, owner's ack=1. Next state: RD_WAIT.
- RD_WAIT: on `mem_response_valid`, forward `mem_fill_data` to the owner with its `*_fill_valid`=1 in the same cycle (combinational pass-through). Next state: IDLE.
- WR: `mem_req`=1, `mem_store`=1, `mem_address`=line address | beat, `mem_evict_data`=word[beat]. `dc_ack`=1 only on beat 0. After beat FF_PER_LINE-1, go to IDLE.
- `mem_response_valid` in any state other than RD_WAIT is dropped and never forwarded.
- Non-owner `*_fill_valid` is always 0. `*_fill_data` may carry `mem_fill_data` unconditionally.

## Timing
- Reset value of every output is 0. The captured registers, the round-robin pointer (= dcache), and the beat counter are all cleared.
- After reset deassertion, the first grant occurs at the edge ending cycle DATA_TRANSFER_TIME+1.
- Read:
  - Request sampled at edge E; `mem_req`/ack high in cycle E+1.
  - Fill valid DATA_TRANSFER_TIME cycles later.
  - The next grant is possible at the edge ending the fill cycle.
  - Occupancy is 1+DATA_TRANSFER_TIME cycles.
- Write: FF_PER_LINE consecutive store cycles, with no gaps; the next grant is possible at the edge ending the last beat.
- Requesters must drop or change `*_req` the cycle after ack; the ack-cycle value is ignored.
- Reset mid-operation aborts the read or burst immediately and enters FLUSH. A partially written line is acceptable.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the requester not granted last; the pointer updates on every grant.
- Undefined: fixed priority, dcache always wins.
- Single-requester behaviour is identical in both builds.

## Structure
- Package `mem_arb_pkg`: state enum, owner enum (IC/DC), FF_PER_LINE and BEAT_BITS derivation functions.
- Sub-module `mem_arb_pick`: two-input grant selection, with the round-robin pointer under the macro.
- FSM, capture registers, and beat/flush counters stay in `mem_arbiter`.

## Test plan
- Reset held 3 cycles, then `ic_req` at 0x40 immediately -> no `mem_req` for 5 cycles; the read is then issued, and `ic_fill_valid` arrives exactly 5 cycles after `mem_req`.
- Dcache eviction of 0x100 with data 0xDDDD_CCCC_BBBB_AAAA_... -> four store beats at 0x100..0x103 carrying AAAA, BBBB, CCCC, DDDD words. A following dc read at 0x101 returns the same 128 bits on `dc_fill_valid`.
- `ic_req` and `dc_req` both asserted for 3 grants: round-robin build gives DC, IC, DC; the build without the macro gives DC, DC, DC with IC stalled.
- Read address 0x47 -> `mem_address` = 0x44.
- Reset asserted in RD_WAIT 2 cycles after `mem_req` -> the stale `mem_response_valid` 3 cycles later is not forwarded, and no ack is issued until FLUSH ends.
- `mem_response_valid` injected while in IDLE -> both `*_fill_valid` outputs remain 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and line-geometry helpers for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR      = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  function automatic int ff_per_line(input int fill_w, input int store_w);
    return fill_w / store_w;
  endfunction

  function automatic int beat_bits(input int ff);
    return (ff > 1) ? $clog2(ff) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Two-input grant selection; round-robin pointer when
//            MEM_ARB_ROUND_ROBIN_EN is defined, otherwise dcache priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   i_grant_en,
`endif
  input  logic   i_ic_req,
  input  logic   i_dc_req,
  output logic   o_valid,
  output owner_e o_owner
);

  assign o_valid = i_ic_req | i_dc_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_prio names the requester that wins the next contended cycle.
  owner_e r_prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= OWN_DC;
    end else if (i_grant_en) begin
      r_prio <= (o_owner == OWN_DC) ? OWN_IC : OWN_DC;
    end
  end

  always_comb begin
    o_owner = OWN_IC;
    if (i_ic_req && i_dc_req) begin
      o_owner = r_prio;
    end else if (i_dc_req) begin
      o_owner = OWN_DC;
    end
  end
`else
  assign o_owner = i_dc_req ? OWN_DC : OWN_IC;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : icache/dcache front end for the shared memory; splits evictions
//            into word stores and routes fills. Option: MEM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int FILL_DATA_WIDTH    = 128,
  parameter int STORE_DATA_WIDTH   = 32,
  parameter int DATA_TRANSFER_TIME = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ic_req,
  input  logic [ADDRESS_WIDTH-1:0]    ic_address,
  output logic                        ic_ack,
  output logic                        ic_fill_valid,
  output logic [FILL_DATA_WIDTH-1:0]  ic_fill_data,
  input  logic                        dc_req,
  input  logic                        dc_store,
  input  logic [ADDRESS_WIDTH-1:0]    dc_address,
  input  logic [FILL_DATA_WIDTH-1:0]  dc_evict_data,
  output logic                        dc_ack,
  output logic                        dc_fill_valid,
  output logic [FILL_DATA_WIDTH-1:0]  dc_fill_data,
  output logic                        mem_req,
  output logic                        mem_store,
  output logic [ADDRESS_WIDTH-1:0]    mem_address,
  output logic [STORE_DATA_WIDTH-1:0] mem_evict_data,
  input  logic [FILL_DATA_WIDTH-1:0]  mem_fill_data,
  input  logic                        mem_response_valid
);

  localparam int FF_PER_LINE = ff_per_line(FILL_DATA_WIDTH, STORE_DATA_WIDTH);
  localparam int BEAT_BITS   = beat_bits(FF_PER_LINE);
  localparam int CNT_W       = (DATA_TRANSFER_TIME > 1) ? $clog2(DATA_TRANSFER_TIME + 1) : 1;

  localparam logic [CNT_W-1:0]         c_flush_load = CNT_W'(DATA_TRANSFER_TIME);
  localparam logic [BEAT_BITS-1:0]     c_last_beat  = BEAT_BITS'(FF_PER_LINE - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_line_mask  = ~ADDRESS_WIDTH'(FF_PER_LINE - 1);

  arb_state_e                  r_state, w_state_nxt;
  owner_e                      r_owner;
  logic [ADDRESS_WIDTH-1:0]    r_addr;
  logic [FILL_DATA_WIDTH-1:0]  r_evict;
  logic [BEAT_BITS-1:0]        r_beat, w_beat_nxt;
  logic [CNT_W-1:0]            r_flush_cnt, w_flush_nxt;
  logic                        w_grant_en, w_grant_take;
  logic                        w_pick_valid;
  owner_e                      w_pick_owner;
  logic [STORE_DATA_WIDTH-1:0] w_word;

  assign w_grant_take = w_grant_en & w_pick_valid;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .rst        (reset),
    .i_grant_en (w_grant_take),
`endif
    .i_ic_req   (ic_req),
    .i_dc_req   (dc_req),
    .o_valid    (w_pick_valid),
    .o_owner    (w_pick_owner)
  );

  always_comb begin
    w_word = '0;
    for (int i = 0; i < FF_PER_LINE; i++) begin
      if (r_beat == BEAT_BITS'(i)) w_word = r_evict[i*STORE_DATA_WIDTH +: STORE_DATA_WIDTH];
    end
  end

  // Arbitration also runs in the fill cycle and on the last store beat so
  // back-to-back transactions leave no idle cycle on the memory port.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_nxt     = r_beat;
    w_flush_nxt    = r_flush_cnt;
    w_grant_en     = 1'b0;
    ic_ack         = 1'b0;
    dc_ack         = 1'b0;
    ic_fill_valid  = 1'b0;
    dc_fill_valid  = 1'b0;
    ic_fill_data   = '0;
    dc_fill_data   = '0;
    mem_req        = 1'b0;
    mem_store      = 1'b0;
    mem_address    = '0;
    mem_evict_data = '0;
    case (r_state)
      ST_FLUSH: begin
        if (r_flush_cnt <= CNT_W'(1)) begin
          w_flush_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_nxt = r_flush_cnt - 1'b1;
        end
      end
      ST_IDLE: w_grant_en = 1'b1;
      ST_RD_REQ: begin
        mem_req     = 1'b1;
        mem_address = r_addr;
        ic_ack      = (r_owner == OWN_IC);
        dc_ack      = (r_owner == OWN_DC);
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_response_valid) begin
          if (r_owner == OWN_IC) begin
            ic_fill_valid = 1'b1;
            ic_fill_data  = mem_fill_data;
          end else begin
            dc_fill_valid = 1'b1;
            dc_fill_data  = mem_fill_data;
          end
          w_state_nxt = ST_IDLE;
          w_grant_en  = 1'b1;
        end
      end
      ST_WR: begin
        mem_req        = 1'b1;
        mem_store      = 1'b1;
        mem_address    = r_addr | ADDRESS_WIDTH'(r_beat);
        mem_evict_data = w_word;
        dc_ack         = (r_beat == '0);
        w_beat_nxt     = r_beat + 1'b1;
        if (r_beat == c_last_beat) begin
          w_state_nxt = ST_IDLE;
          w_grant_en  = 1'b1;
        end
      end
      default: w_state_nxt = ST_FLUSH;
    endcase
    if (w_grant_take) begin
      w_beat_nxt  = '0;
      w_state_nxt = (w_pick_owner == OWN_DC && dc_store) ? ST_WR : ST_RD_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= c_flush_load;
      r_beat      <= '0;
      r_owner     <= OWN_IC;
      r_addr      <= '0;
      r_evict     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_beat      <= w_beat_nxt;
      if (w_grant_take) begin
        r_owner <= w_pick_owner;
        r_addr  <= ((w_pick_owner == OWN_DC) ? dc_address : ic_address) & c_line_mask;
        r_evict <= dc_evict_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a small
//            word-addressed memory model behind it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int FW  = 128;
  localparam int SW  = 32;
  localparam int DTT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, ic_ack, ic_fill_valid;
  logic [AW-1:0] ic_address;
  logic [FW-1:0] ic_fill_data;
  logic          dc_req, dc_store, dc_ack, dc_fill_valid;
  logic [AW-1:0] dc_address;
  logic [FW-1:0] dc_evict_data, dc_fill_data;
  logic          mem_req, mem_store, mem_response_valid;
  logic [AW-1:0] mem_address;
  logic [SW-1:0] mem_evict_data;
  logic [FW-1:0] mem_fill_data;

  logic          preload, inject;
  logic [31:0]   mem_words [0:1023];
  logic          pipe_v [1:DTT];
  logic [FW-1:0] pipe_d [1:DTT];

  int n_checks = 0;
  int n_err    = 0;
  int ng;
  int grants [3];
  logic [31:0] ew [4];

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDRESS_WIDTH      (AW),
    .FILL_DATA_WIDTH    (FW),
    .STORE_DATA_WIDTH   (SW),
    .DATA_TRANSFER_TIME (DTT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ic_req             (ic_req),
    .ic_address         (ic_address),
    .ic_ack             (ic_ack),
    .ic_fill_valid      (ic_fill_valid),
    .ic_fill_data       (ic_fill_data),
    .dc_req             (dc_req),
    .dc_store           (dc_store),
    .dc_address         (dc_address),
    .dc_evict_data      (dc_evict_data),
    .dc_ack             (dc_ack),
    .dc_fill_valid      (dc_fill_valid),
    .dc_fill_data       (dc_fill_data),
    .mem_req            (mem_req),
    .mem_store          (mem_store),
    .mem_address        (mem_address),
    .mem_evict_data     (mem_evict_data),
    .mem_fill_data      (mem_fill_data),
    .mem_response_valid (mem_response_valid)
  );

  // Memory stand-in: stores land immediately, reads return DTT cycles later.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_words[i] <= 32'h5000_0000 | i;
      for (int k = 1; k <= DTT; k++) pipe_v[k] <= 1'b0;
    end else begin
      if (mem_req && mem_store) mem_words[mem_address[9:0]] <= mem_evict_data;
      pipe_v[1] <= mem_req && !mem_store;
      pipe_d[1] <= {mem_words[{mem_address[9:2], 2'd3}], mem_words[{mem_address[9:2], 2'd2}],
                    mem_words[{mem_address[9:2], 2'd1}], mem_words[{mem_address[9:2], 2'd0}]};
      for (int k = 2; k <= DTT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end

  assign mem_response_valid = pipe_v[DTT] | inject;
  assign mem_fill_data      = pipe_d[DTT];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1; inject = 1'b0;
    ic_req = 1'b0; ic_address = '0;
    dc_req = 1'b0; dc_store = 1'b0; dc_address = '0; dc_evict_data = '0;
    ew[0] = 32'hAAAA_AAAA; ew[1] = 32'hBBBB_BBBB; ew[2] = 32'hCCCC_CCCC; ew[3] = 32'hDDDD_DDDD;

    @(negedge clk);
    preload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_acks", {ic_ack, dc_ack}, 0);
    chk("rst_fill_valid", {ic_fill_valid, dc_fill_valid}, 0);
    chk("rst_mem_addr", mem_address, 0);

    // First read straight out of reset must wait for the flush window.
    reset = 1'b0; ic_req = 1'b1; ic_address = 32'h40;
    for (int k = 1; k <= DTT; k++) begin
      @(negedge clk);
      chk("flush_no_req", {mem_req, ic_ack}, 0);
    end
    @(negedge clk);
    chk("rd0_req", {mem_req, mem_store, ic_ack, dc_ack}, 4'b1010);
    chk("rd0_addr", mem_address, 32'h40);
    ic_req = 1'b0;
    for (int k = 1; k < DTT; k++) begin
      @(negedge clk);
      chk("rd0_early_fill", ic_fill_valid, 0);
    end
    @(negedge clk);
    chk("rd0_fill_valid", {ic_fill_valid, dc_fill_valid}, 2'b10);
    chk("rd0_fill_data", ic_fill_data, 128'h50000043_50000042_50000041_50000040);

    // Eviction granted at the edge ending the fill cycle.
    dc_req = 1'b1; dc_store = 1'b1; dc_address = 32'h100;
    dc_evict_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    @(negedge clk);
    chk("wr0_ctrl", {mem_req, mem_store, dc_ack}, 3'b111);
    chk("wr0_addr", mem_address, 32'h100);
    chk("wr0_data", mem_evict_data, ew[0]);
    dc_req = 1'b0;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chk("wr_ctrl", {mem_req, mem_store, dc_ack}, 3'b110);
      chk("wr_addr", mem_address, 32'h100 + b);
      chk("wr_data", mem_evict_data, ew[b]);
    end
    dc_req = 1'b1; dc_store = 1'b0; dc_address = 32'h101;
    @(negedge clk);
    chk("dcrd_ctrl", {mem_req, mem_store, dc_ack, ic_ack}, 4'b1010);
    chk("dcrd_addr", mem_address, 32'h100);
    dc_req = 1'b0;
    for (int k = 1; k < DTT; k++) @(negedge clk);
    chk("dcrd_early_fill", dc_fill_valid, 0);
    @(negedge clk);
    chk("dcrd_fill_valid", {ic_fill_valid, dc_fill_valid}, 2'b01);
    chk("dcrd_fill_data", dc_fill_data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

    // Spurious response while idle.
    @(negedge clk);
    inject = 1'b1;
    #1;
    chk("idle_inject", {ic_fill_valid, dc_fill_valid}, 0);
    inject = 1'b0;

    // Reset during RD_WAIT; the late response must be swallowed by FLUSH.
    ic_req = 1'b1; ic_address = 32'h80;
    @(negedge clk);
    chk("rst_rd_req", {mem_req, ic_ack}, 2'b11);
    ic_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; ic_req = 1'b1; ic_address = 32'h47;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_quiet", {mem_req, ic_ack, ic_fill_valid, dc_fill_valid}, 0);
      if (k == 0) reset = 1'b0;
    end
    @(negedge clk);
    chk("align_req", {mem_req, ic_ack}, 2'b11);
    chk("align_addr", mem_address, 32'h44);
    ic_req = 1'b0;
    for (int k = 1; k < DTT; k++) @(negedge clk);
    @(negedge clk);
    chk("align_fill", {ic_fill_valid, ic_fill_data},
        {1'b1, 128'h50000047_50000046_50000045_50000044});

    // Contention: both requesters held for three grants.
    ic_req = 1'b1; ic_address = 32'h80;
    dc_req = 1'b1; dc_store = 1'b0; dc_address = 32'h200;
    ng = 0;
    grants[0] = 0; grants[1] = 0; grants[2] = 0;
    for (int t = 0; t < 40 && ng < 3; t++) begin
      @(negedge clk);
      if (dc_ack) begin
        grants[ng] = 1; ng++;
      end else if (ic_ack) begin
        grants[ng] = 2; ng++;
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    chk("arb_grant_count", ng, 3);
    chk("arb_g0", grants[0], 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("arb_g1", grants[1], 2);
`else
    chk("arb_g1", grants[1], 1);
`endif
    chk("arb_g2", grants[2], 1);
    repeat (8) @(negedge clk);
    chk("end_idle", {mem_req, ic_ack, dc_ack}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
